// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the RV32I core
package core_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_MISS  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - enable/flush pipeline register (pc, inst, valid)
module ifid_reg #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            flush,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] d_inst,
    input  logic            d_valid,
    output logic [XLEN-1:0] q_pc,
    output logic [XLEN-1:0] q_inst,
    output logic            q_valid
);

    // Flush wins over enable so a bubble can never be overwritten by a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pc    <= '0;
            q_inst  <= NOP_INST[XLEN-1:0];
            q_valid <= 1'b0;
        end else if (flush) begin
            q_pc    <= '0;
            q_inst  <= NOP_INST[XLEN-1:0];
            q_valid <= 1'b0;
        end else if (en) begin
            q_pc    <= d_pc;
            q_inst  <= d_inst;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// rtl/fetch_stage_ctrl.sv - PC, IF/ID register and I-cache request sequencer
module fetch_stage_ctrl
    import core_pkg::*;
#(
    parameter int          XLEN     = core_pkg::XLEN,
    parameter logic [31:0] RESET_PC = core_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hazard_stall,
    input  logic            hazard_flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            mem_stall,
    output logic            icache_ren,
    output logic [XLEN-3:0] icache_addr,
    input  logic [XLEN-1:0] icache_rdata,
    input  logic            icache_stall,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_inst,
    output logic            ifid_valid
);

    // PC is kept as a word address; the low two bits are always zero.
    fetch_state_t    state, state_next;
    logic [XLEN-3:0] pc_word, pc_next;
    logic            pend_valid, pend_valid_next;
    logic [XLEN-3:0] pend_pc, pend_pc_next;
    logic            ifid_en, ifid_flush;
    logic            freeze;
    logic [XLEN-3:0] redirect_word;
    logic            unused_redirect_lsbs;

    assign freeze               = mem_stall | icache_stall;
    assign redirect_word        = redirect_pc[XLEN-1:2];
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_BOOT;
            pc_word    <= RESET_PC[XLEN-1:2];
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            state      <= state_next;
            pc_word    <= pc_next;
            pend_valid <= pend_valid_next;
            pend_pc    <= pend_pc_next;
        end
    end

    // S_DROP is only entered together with pend_valid, so the final accept
    // branch is reached only from S_FETCH or S_MISS.
    always_comb begin
        state_next      = state;
        pc_next         = pc_word;
        pend_valid_next = pend_valid;
        pend_pc_next    = pend_pc;
        ifid_en         = 1'b0;
        ifid_flush      = 1'b0;

        if (state == S_BOOT) begin
            state_next = S_FETCH;
        end else if (redirect_valid && freeze) begin
            pend_valid_next = 1'b1;
            pend_pc_next    = redirect_word;
            state_next      = icache_stall ? S_DROP : S_FETCH;
        end else if (redirect_valid) begin
            pc_next         = redirect_word;
            ifid_flush      = 1'b1;
            pend_valid_next = 1'b0;
            state_next      = S_FETCH;
        end else if (freeze) begin
            if (icache_stall) begin
                if (state == S_FETCH) begin
                    state_next = S_MISS;
                end
            end else begin
                state_next = S_FETCH;
            end
        end else if (pend_valid) begin
            // Deferred redirect: drops any wrong-path data returned this cycle.
            pc_next         = pend_pc;
            ifid_flush      = 1'b1;
            pend_valid_next = 1'b0;
            state_next      = S_FETCH;
        end else if (hazard_stall) begin
            state_next = S_FETCH;
        end else if (hazard_flush) begin
            ifid_flush = 1'b1;
            pc_next    = pc_word + 1'b1;
            state_next = S_FETCH;
        end else begin
            ifid_en    = 1'b1;
            pc_next    = pc_word + 1'b1;
            state_next = S_FETCH;
        end
    end

    assign icache_ren  = (state != S_BOOT);
    assign icache_addr = pc_word;

    ifid_reg #(
        .XLEN     (XLEN),
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ifid_en),
        .flush   (ifid_flush),
        .d_pc    ({pc_word, 2'b00}),
        .d_inst  (icache_rdata),
        .d_valid (1'b1),
        .q_pc    (ifid_pc),
        .q_inst  (ifid_inst),
        .q_valid (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb/tb_fetch_stage_ctrl.sv - directed self-checking bench for fetch_stage_ctrl
module tb_fetch_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hazard_stall;
    logic        hazard_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_stall;
    logic        icache_ren;
    logic [29:0] icache_addr;
    logic [31:0] icache_rdata;
    logic        icache_stall;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_valid;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fetch_stage_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hazard_stall   (hazard_stall),
        .hazard_flush   (hazard_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_stall      (mem_stall),
        .icache_ren     (icache_ren),
        .icache_addr    (icache_addr),
        .icache_rdata   (icache_rdata),
        .icache_stall   (icache_stall),
        .ifid_pc        (ifid_pc),
        .ifid_inst      (ifid_inst),
        .ifid_valid     (ifid_valid)
    );

    // Instruction memory: words 0/1 fixed, others tagged with their word address.
    always_comb begin
        if (icache_addr == 30'd0)
            icache_rdata = 32'h0050_0093;
        else if (icache_addr == 30'd1)
            icache_rdata = 32'h0010_0113;
        else
            icache_rdata = 32'hA000_0000 | {2'b00, icache_addr};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc,
                              input logic [31:0] inst, input logic valid);
        check({tag, ".pc"}, ifid_pc, pc);
        check({tag, ".inst"}, ifid_inst, inst);
        check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    endtask

    initial begin
        rst_n          = 1'b0;
        hazard_stall   = 1'b0;
        hazard_flush   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        mem_stall      = 1'b0;
        icache_stall   = 1'b0;
        step();
        check("rst.ren", {31'd0, icache_ren}, 32'd0);
        check("rst.addr", {2'b00, icache_addr}, 32'd0);
        check_ifid("rst", 32'd0, 32'h13, 1'b0);

        // 1: boot cycle then back-to-back hits
        rst_n = 1'b1;
        step();
        check("boot.ren", {31'd0, icache_ren}, 32'd1);
        check("boot.addr", {2'b00, icache_addr}, 32'd0);
        check("boot.valid", {31'd0, ifid_valid}, 32'd0);
        step();
        check_ifid("hit0", 32'd0, 32'h0050_0093, 1'b1);
        check("hit0.addr", {2'b00, icache_addr}, 32'd1);
        step();
        check_ifid("hit1", 32'd4, 32'h0010_0113, 1'b1);
        check("hit1.addr", {2'b00, icache_addr}, 32'd2);

        // 2: hazard_stall holds pc=8 and IF/ID for two cycles
        hazard_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_ifid("hstall", 32'd4, 32'h0010_0113, 1'b1);
            check("hstall.addr", {2'b00, icache_addr}, 32'd2);
        end
        hazard_stall = 1'b0;
        step();
        check_ifid("hresume", 32'd8, 32'hA000_0002, 1'b1);
        step();
        check("pc10.addr", {2'b00, icache_addr}, 32'd4);

        // 3: redirect with no freeze, hazard_stall ignored
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        hazard_stall   = 1'b1;
        step();
        redirect_valid = 1'b0;
        hazard_stall   = 1'b0;
        check_ifid("redir", 32'd0, 32'h13, 1'b0);
        check("redir.addr", {2'b00, icache_addr}, 32'h10);
        step();
        check_ifid("redir.hit", 32'h40, 32'hA000_0010, 1'b1);

        // 4: miss at 0x20 with a redirect to 0x80 arriving mid-miss
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1E;
        step();
        redirect_valid = 1'b0;
        check("mis.trunc", {2'b00, icache_addr}, 32'h7);
        step();
        check_ifid("mis.pre", 32'h1C, 32'hA000_0007, 1'b1);
        icache_stall = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            redirect_valid = (c == 2);
            redirect_pc    = 32'h80;
            step();
        end
        redirect_valid = 1'b0;
        check_ifid("mis.hold", 32'h1C, 32'hA000_0007, 1'b1);
        check("mis.hold.addr", {2'b00, icache_addr}, 32'h8);
        icache_stall = 1'b0;
        step();
        check_ifid("mis.drop", 32'd0, 32'h13, 1'b0);
        check("mis.newaddr", {2'b00, icache_addr}, 32'h20);
        step();
        check_ifid("mis.after", 32'h80, 32'hA000_0020, 1'b1);

        // 5: mem_stall + flush + redirect in the same cycle
        mem_stall      = 1'b1;
        hazard_flush   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        hazard_flush   = 1'b0;
        redirect_valid = 1'b0;
        check_ifid("ms.hold", 32'h80, 32'hA000_0020, 1'b1);
        check("ms.hold.addr", {2'b00, icache_addr}, 32'h21);
        step();
        check("ms.hold2.addr", {2'b00, icache_addr}, 32'h21);
        mem_stall = 1'b0;
        step();
        check_ifid("ms.apply", 32'd0, 32'h13, 1'b0);
        check("ms.apply.addr", {2'b00, icache_addr}, 32'h40);
        step();
        check_ifid("ms.after", 32'h100, 32'hA000_0040, 1'b1);

        // hazard_flush alone: bubble and pc advances
        hazard_flush = 1'b1;
        step();
        hazard_flush = 1'b0;
        check_ifid("hflush", 32'd0, 32'h13, 1'b0);
        check("hflush.addr", {2'b00, icache_addr}, 32'h42);

        // 6: pc wrap-around, then reset in the middle of a miss
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap.addr", {2'b00, icache_addr}, 32'h3FFF_FFFF);
        step();
        check_ifid("wrap", 32'hFFFF_FFFC, 32'hBFFF_FFFF, 1'b1);
        check("wrap.addr0", {2'b00, icache_addr}, 32'd0);
        step();
        check_ifid("wrap.hit0", 32'd0, 32'h0050_0093, 1'b1);
        icache_stall = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.ren", {31'd0, icache_ren}, 32'd0);
        check("arst.addr", {2'b00, icache_addr}, 32'd0);
        check_ifid("arst", 32'd0, 32'h13, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        icache_stall = 1'b0;
        check("boot2.ren", {31'd0, icache_ren}, 32'd1);
        check("boot2.valid", {31'd0, ifid_valid}, 32'd0);
        step();
        check_ifid("boot2.hit", 32'd0, 32'h0050_0093, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
PC register, IF/ID pipeline register and I-cache request sequencer for the 5-stage RV32I pipeline.
Consumes the hazard unit's hazard_stall/hazard_flush and the ID-stage branch redirect, and applies them to PC and IF/ID.
Tracks outstanding I-cache misses so a redirect arriving mid-miss is neither lost nor fetched down the wrong path.
Sits between the I-cache and the ID stage.

Parameters:
XLEN, 32, PC / instruction width
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hazard_stall  in  1  hold PC and IF/ID (load-use, branch-operand wait)
hazard_flush  in  1  replace IF/ID contents with bubble
redirect_valid  in  1  branch/jump taken, resolved in ID
redirect_pc  in  XLEN  target of taken branch/jump
mem_stall  in  1  D-cache stall; freezes whole pipeline
icache_ren  out  1  I-cache read request
icache_addr  out  XLEN-2  word address = pc[XLEN-1:2]
icache_rdata  in  XLEN  instruction; valid in any cycle icache_ren=1 and icache_stall=0
icache_stall  in  1  I-cache miss in progress
ifid_pc  out  XLEN  PC of instruction in IF/ID
ifid_inst  out  XLEN  instruction in IF/ID
ifid_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; ifid_pc=0; ifid_inst=NOP_INST; ifid_valid=0.
  - pend_valid=0; pend_pc=0; state=S_BOOT; icache_ren=0.
- States:
  - S_BOOT: one cycle, icache_ren=0, then S_FETCH.
  - S_FETCH: icache_ren=1, normal fetch.
  - S_MISS: icache_ren=1, correct-path miss outstanding.
  - S_DROP: icache_ren=1, wrong-path miss outstanding; returned data discarded.
- freeze = mem_stall | icache_stall. An accept happens in a cycle where state in {S_FETCH,S_MISS}, icache_ren=1 and freeze=0.
- Priority per cycle, highest first:
  1. Redirect while frozen:
     - pend_valid<=1, pend_pc<=redirect_pc.
     - If icache_stall, the state moves to S_DROP.
     - PC and IF/ID hold.
  2. Redirect, not frozen:
     - pc<=redirect_pc; IF/ID<=bubble (ifid_valid=0, ifid_inst=NOP_INST, ifid_pc=0).
     - hazard_stall is ignored.
  3. freeze with no redirect:
     - PC, IF/ID, pend_* hold.
     - S_FETCH to S_MISS when icache_stall=1.
  4. hazard_stall=1, with or without hazard_flush: PC and IF/ID hold. The bubble is inserted downstream via the hazard mux, not here.
  5. hazard_flush=1, hazard_stall=0: IF/ID<=bubble; pc<=pc+4.
  6. Accept:
     - ifid_inst<=icache_rdata, ifid_pc<=pc, ifid_valid<=1.
     - pc<=pc+4, with wrap-around at 2^XLEN.
- Miss completion (icache_stall falls):
  - In S_MISS, the state returns to S_FETCH and the instruction is accepted that cycle under rules 3-6.
  - In S_DROP, rdata is discarded, pc<=pend_pc, pend_valid<=0, IF/ID<=bubble, state to S_FETCH.
  - A held pend_valid is also applied when mem_stall alone clears: pc<=pend_pc, IF/ID<=bubble.
- A second redirect while pend_valid=1 overwrites pend_pc (last wins).
- pc[1:0] is forced to 00 on every load. A misaligned redirect_pc is truncated, with no trap.
- Latency: fetch address to IF/ID is one cycle on a hit; miss adds the I-cache stall cycles.
- Reset mid-miss: everything returns to reset values immediately. A subsequent stale icache_stall deassertion in S_BOOT is ignored.

Decomposition:
- Shared package core_pkg holds:
  - XLEN, RESET_PC, NOP_INST;
  - fetch state enum {S_BOOT,S_FETCH,S_MISS,S_DROP};
  - OPC_BRANCH=7'b1100011, OPC_LOAD=7'b0000011.
- One sub-module ifid_reg: enable/flush pipeline register with async reset, reusable for ID/EX.

Test Plan:
1. Reset release, I-cache always hits, rdata=0x00500093 then 0x00100113:
   - cycle 1 after S_BOOT: icache_addr=0;
   - next edge: ifid_pc=0, ifid_inst=0x00500093, ifid_valid=1;
   - pc=4.
2. hazard_stall=1 for 2 cycles with pc=8: pc stays 8 and IF/ID unchanged for 2 cycles, then resumes with ifid_pc=8.
3. redirect_valid=1, redirect_pc=0x40, pc=0x10, no freeze: next cycle pc=0x40, ifid_valid=0, ifid_inst=0x00000013.
4. Miss at pc=0x20, icache_stall=1 for 5 cycles, redirect to 0x80 in cycle 2:
   - on stall release, rdata is discarded and IF/ID gets a bubble;
   - pc=0x80, next fetch address word 0x20.
5. mem_stall=1 with hazard_flush=1 and redirect_pc=0x100 asserted in the same cycle: IF/ID and PC hold; after mem_stall drops, pc=0x100 and IF/ID is a bubble.
6. pc=0xFFFFFFFC, accept: pc wraps to 0x00000000; async rst_n pulse mid-miss returns all outputs to reset values within the same cycle.
